// File: rtl/data_ram_if.sv
// MEM-stage data RAM request/response bundle.
// The pipeline (master) drives the request; the RAM responder (slave) answers it.
interface data_ram_if;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        ram_stall;
    logic        ram_ready;
    logic        ram_addr_err;

    modport master (
        output ram_en, ram_write_en, ram_addr, ram_write_data,
        input  ram_read_data, ram_stall, ram_ready, ram_addr_err
    );

    modport slave (
        input  ram_en, ram_write_en, ram_addr, ram_write_data,
        output ram_read_data, ram_stall, ram_ready, ram_addr_err
    );
endinterface

// File: rtl/data_ram_responder.sv
// Data RAM responder: word-organised, byte-lane-writable array that answers a
// MEM-stage request after WAIT_CYCLES wait states, stalling the pipeline meanwhile.
module data_ram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    data_ram_if.slave  ram_if
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [3:0]             we_q, we_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            mem [DEPTH];

    logic                   accept;
    logic                   commit;
    logic                   req_err;
    logic [ADDR_WIDTH-1:0]  req_idx;
    logic [ADDR_WIDTH-1:0]  c_idx;
    logic [3:0]             c_we;
    logic [31:0]            c_wdata;
    logic                   c_err;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^ram_if.ram_addr[1:0];
    assign req_err = |ram_if.ram_addr[31:ADDR_WIDTH+2];
    assign req_idx = ram_if.ram_addr[ADDR_WIDTH+1:2];
    assign accept  = (state_q == IDLE) && ram_if.ram_en;

    // Next-state, counter and request-latch logic of the IDLE/BUSY/DONE controller
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ram_if.ram_en) begin
                    idx_d   = req_idx;
                    we_d    = ram_if.ram_write_en;
                    wdata_d = ram_if.ram_write_data;
                    err_d   = req_err;
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Commit uses the live request when it happens on the acceptance edge, else the latched one
    always_comb begin
        c_idx   = idx_q;
        c_we    = we_q;
        c_wdata = wdata_q;
        c_err   = err_q;
        if (accept) begin
            c_idx   = req_idx;
            c_we    = ram_if.ram_write_en;
            c_wdata = ram_if.ram_write_data;
            c_err   = req_err;
        end
    end

    // Read data only changes when a read commits; an out-of-range read returns zero
    always_comb begin
        rdata_d = rdata_q;
        if (commit && (c_we == 4'd0)) begin
            rdata_d = c_err ? 32'd0 : mem[c_idx];
        end
    end

    // Controller and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 4'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-lane array write on commit; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_we[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ram_if.ram_read_data = rdata_q;
    assign ram_if.ram_stall     = accept || (state_q == BUSY);
    assign ram_if.ram_ready     = (state_q == DONE);
    assign ram_if.ram_addr_err  = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: three instances with WAIT_CYCLES 0, 1 and 2
// share one request driver; sel picks which instance sees ram_en and is observed.
module tb_data_ram_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          sel;

    logic [31:0] rd;
    logic        stall;
    logic        ready;
    logic        aerr;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;

    typedef struct {
        int          s;
        logic [3:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    vec_t vecs [19];

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Cycle counter used to measure spacing between ready pulses
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    data_ram_if ifc0 ();
    data_ram_if ifc1 ();
    data_ram_if ifc2 ();

    assign ifc0.ram_en = en && (sel == 0);
    assign ifc1.ram_en = en && (sel == 1);
    assign ifc2.ram_en = en && (sel == 2);
    assign ifc0.ram_write_en = we;
    assign ifc1.ram_write_en = we;
    assign ifc2.ram_write_en = we;
    assign ifc0.ram_addr = addr;
    assign ifc1.ram_addr = addr;
    assign ifc2.ram_addr = addr;
    assign ifc0.ram_write_data = wdata;
    assign ifc1.ram_write_data = wdata;
    assign ifc2.ram_write_data = wdata;

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .ram_if(ifc0));
    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .ram_if(ifc1));
    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .ram_if(ifc2));

    // Observe the selected instance
    always_comb begin
        case (sel)
            0: begin rd = ifc0.ram_read_data; stall = ifc0.ram_stall; ready = ifc0.ram_ready; aerr = ifc0.ram_addr_err; end
            1: begin rd = ifc1.ram_read_data; stall = ifc1.ram_stall; ready = ifc1.ram_ready; aerr = ifc1.ram_addr_err; end
            default: begin rd = ifc2.ram_read_data; stall = ifc2.ram_stall; ready = ifc2.ram_ready; aerr = ifc2.ram_addr_err; end
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request starting just after a rising edge; scramble the inputs once
    // accepted, then wait (bounded) for ready, sampling on falling edges.
    task automatic applyStimulus(input int s, input logic [3:0] w, input logic [31:0] a,
                                 input logic [31:0] d, input bit holdEn,
                                 output logic [31:0] gotRd, output logic gotErr,
                                 output int lat, output int stallCnt,
                                 output logic doneStall, output int readyCycle);
        sel = s; en = 1'b1; we = w; addr = a; wdata = d;
        lat = -1; stallCnt = 0; gotRd = 32'hx; gotErr = 1'bx; doneStall = 1'bx; readyCycle = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c; gotRd = rd; gotErr = aerr; doneStall = stall; readyCycle = cycleCnt;
                break;
            end
            if (stall) stallCnt++;
            @(posedge clk); #1;
            if (c == 0) begin
                we = ~w; addr = ~a; wdata = ~d;
            end
        end
        if (!holdEn) en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic runAccess(input string tag, input int s, input logic [3:0] w, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] expRd, input logic expErr,
                             input bit holdEn, output int readyCycle);
        logic [31:0] gRd;
        logic gErr, gDs;
        int gLat, gSc;
        applyStimulus(s, w, a, d, holdEn, gRd, gErr, gLat, gSc, gDs, readyCycle);
        checkOutput({tag, " latency"}, gLat, s + 1);
        checkOutput({tag, " stall cycles"}, gSc, s + 1);
        checkOutput({tag, " stall in done"}, {31'd0, gDs}, 32'd0);
        checkOutput({tag, " addr_err"}, {31'd0, gErr}, {31'd0, expErr});
        checkOutput({tag, " read_data"}, gRd, expRd);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rc, rc0, rc1, rc2;

        vecs[0]  = '{1, 4'hF, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[2]  = '{1, 4'hF, 32'h0000_0020, 32'hAABB_CCDD, 32'h1234_5678, 1'b0};
        vecs[3]  = '{1, 4'h4, 32'h0000_0020, 32'h00EE_0000, 32'h1234_5678, 1'b0};
        vecs[4]  = '{1, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'hAAEE_CCDD, 1'b0};
        vecs[5]  = '{0, 4'hF, 32'h0000_0024, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[6]  = '{0, 4'hC, 32'h0000_0024, 32'h9988_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{0, 4'h0, 32'h0000_0024, 32'h0000_0000, 32'h9988_3344, 1'b0};
        vecs[8]  = '{1, 4'hF, 32'h0000_0000, 32'h5A5A_5A5A, 32'hAAEE_CCDD, 1'b0};
        vecs[9]  = '{1, 4'h0, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[10] = '{1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[11] = '{1, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h5A5A_5A5A, 1'b0};
        vecs[12] = '{1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[13] = '{1, 4'h3, 32'h0000_0010, 32'h0000_BEEF, 32'h1234_5678, 1'b0};
        vecs[14] = '{1, 4'h0, 32'h0000_0013, 32'h0000_0000, 32'h1234_BEEF, 1'b0};
        vecs[15] = '{0, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h9988_3344, 1'b0};
        vecs[16] = '{0, 4'h0, 32'h0000_0FFF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[17] = '{2, 4'h0, 32'h8000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[18] = '{2, 4'hF, 32'h0000_0040, 32'h0102_0304, 32'h0000_0000, 1'b0};

        rst_n = 1'b0; en = 1'b0; we = 4'd0; addr = 32'd0; wdata = 32'd0; sel = 0;
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            checkOutput($sformatf("reset%0d read_data", s), rd, 32'd0);
            checkOutput($sformatf("reset%0d ready", s), {31'd0, ready}, 32'd0);
            checkOutput($sformatf("reset%0d addr_err", s), {31'd0, aerr}, 32'd0);
            checkOutput($sformatf("reset%0d stall", s), {31'd0, stall}, 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            runAccess($sformatf("vec%0d", i), vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d,
                      vecs[i].expRd, vecs[i].expErr, 1'b0, rc);
        end

        $display("[TB] reset during BUSY, WAIT_CYCLES=2");
        sel = 2; en = 1'b1; we = 4'hF; addr = 32'h0000_0040; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("rstbusy stall T", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        checkOutput("rstbusy ready busy1", {31'd0, ready}, 32'd0);
        checkOutput("rstbusy stall busy1", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rstbusy ready c%0d", c), {31'd0, ready}, 32'd0);
            checkOutput($sformatf("rstbusy stall c%0d", c), {31'd0, stall}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        runAccess("rstbusy readback", 2, 4'h0, 32'h0000_0040, 32'd0, 32'h0102_0304, 1'b0, 1'b0, rc);

        $display("[TB] reset during DONE, WAIT_CYCLES=1");
        sel = 1; en = 1'b1; we = 4'h0; addr = 32'h0000_0020; wdata = 32'd0;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstdone ready before", {31'd0, ready}, 32'd1);
        checkOutput("rstdone data before", rd, 32'hAAEE_CCDD);
        rst_n = 1'b0;
        #1;
        checkOutput("rstdone ready after", {31'd0, ready}, 32'd0);
        checkOutput("rstdone data after", rd, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] back-to-back reads, WAIT_CYCLES=2");
        runAccess("b2b read0", 2, 4'h0, 32'h0000_0040, 32'd0, 32'h0102_0304, 1'b0, 1'b1, rc0);
        runAccess("b2b read1", 2, 4'h0, 32'h2000_0040, 32'd0, 32'h0000_0000, 1'b1, 1'b1, rc1);
        runAccess("b2b read2", 2, 4'h0, 32'h0000_0040, 32'd0, 32'h0102_0304, 1'b0, 1'b0, rc2);
        checkOutput("b2b spacing 0-1", rc1 - rc0, 32'd4);
        checkOutput("b2b spacing 1-2", rc2 - rc1, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder end of the MEM-stage data RAM request interface.
- Accepts the combinational request `{ram_en, ram_write_en, ram_addr, ram_write_data}`.
- Serves it from an internal word-organised, byte-lane-writable array after a configurable number of wait states.
- Holds the pipeline with `ram_stall` until the access completes, then returns read data, `ram_ready` and an address-error flag to the MEM/WB path.

Parameters:
- ADDR_WIDTH, 10, word-index bits; array depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1, extra cycles between acceptance and commit; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ram_en  input  1  request valid; high for any load or store.
- ram_write_en  input  4  byte-lane write strobes; 0 with ram_en=1 means read.
- ram_addr  input  32  byte address; bits [1:0] are ignored (already word aligned).
- ram_write_data  input  32  store data, already lane-shifted.
- ram_read_data  output  32  full word read; valid in the ram_ready cycle and held until the next read completes.
- ram_stall  output  1  pipeline hold request.
- ram_ready  output  1  one-cycle pulse: access completed.
- ram_addr_err  output  1  one-cycle pulse with ram_ready: address outside the array.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, counter=0.
  - ram_read_data=0, ram_ready=0, ram_addr_err=0; ram_stall=0 once ram_en is low.
  - Array contents are not cleared.
- State machine IDLE / BUSY / DONE:
  - IDLE, ram_en=1 at edge of cycle T:
    - Latch addr, write_en, write_data.
    - Set err = (ram_addr[31:ADDR_WIDTH+2] != 0).
    - If WAIT_CYCLES=0, commit at this same edge and go to DONE.
    - Otherwise load counter=WAIT_CYCLES and go to BUSY.
  - BUSY: decrement counter each cycle. In the cycle where counter==1, commit at the edge and go to DONE.
  - DONE: ram_ready=1 and ram_addr_err=err for exactly this cycle. Go to IDLE unconditionally; ram_en is ignored in DONE because the pipeline advances at the end of this cycle.
- Commit rules:
  - Write (latched write_en!=0, err=0): for each set bit i, array[addr[ADDR_WIDTH+1:2]] byte i <= write_data[8i+7:8i]. Unset lanes are unchanged. ram_read_data is unchanged.
  - Read (write_en=0, err=0): ram_read_data <= array word.
  - err=1: no array write; a read loads ram_read_data <= 0.
- Timing:
  - Acceptance at cycle T; ram_ready in cycle T+WAIT_CYCLES+1.
  - ram_stall = (state==IDLE && ram_en) || state==BUSY.
  - ram_stall is combinational from ram_en in IDLE and is high for cycles T..T+WAIT_CYCLES. It is low in DONE.
- Boundary conditions:
  - Back-to-back requests: ram_en high in the cycle after DONE is accepted as a new request; minimum spacing is one request per WAIT_CYCLES+2 cycles.
  - Input changes while BUSY are ignored; latched values are used.
  - Read then write to the same word: the read returns the old value; the write becomes visible to the next read.
  - Reset asserted in BUSY before the commit edge: no write occurs and ram_ready does not pulse. Reset in DONE clears ram_ready immediately.
  - Counter width is 4 bits; no wrap is possible within the legal parameter range.

Test Plan:
- Reset mid-write:
  - Stimulus: WAIT_CYCLES=2; write 0xDEADBEEF to 0x0000_0040 with write_en=4'b1111; assert rst_n=0 in the second BUSY cycle.
  - Response: no ram_ready pulse; a later read of 0x40 returns the prior value.
- Full-word write then read, WAIT_CYCLES=1:
  - Stimulus: write 0x12345678 to addr 0x0000_0010 with write_en=4'b1111; release the pipeline; read 0x10.
  - Response: ram_stall high 2 cycles per access; ram_ready in cycle T+2; ram_read_data=0x12345678.
- Byte lanes:
  - Stimulus: preload 0xAABBCCDD at 0x20; write 0x00EE0000 with write_en=4'b0100; read 0x20.
  - Response: ram_read_data=0xAAEECCDD.
- Half word, WAIT_CYCLES=0:
  - Stimulus: write 0x99880000 with write_en=4'b1100 to 0x24 (holding 0x11223344); read 0x24.
  - Response: ram_ready in cycle T+1; data=0x99883344.
- Out-of-range address:
  - Stimulus: ADDR_WIDTH=10; read 0x0000_1000; write 0xFFFFFFFF to 0x0000_1000.
  - Response: both accesses give ram_addr_err=1 together with ram_ready; the read returns ram_read_data=0; array word 0 is unchanged.
- Back-to-back:
  - Stimulus: three reads with ram_en held continuously.
  - Response: ram_ready pulses spaced WAIT_CYCLES+2 cycles apart; ram_stall low only in DONE cycles.
